// File: rtl/gshare_pht.sv
// Gshare pattern history table: 2-bit saturating counters indexed by PC ^ global history,
// self-initialised to weakly-not-taken by a sweep after reset, one-cycle registered prediction.
module gshare_pht #(
    parameter int IDX_W = 8,
    parameter int PC_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pred_valid,
    input  logic [PC_W-1:0]  pred_pc,
    input  logic [IDX_W-1:0] pred_ghr,
    output logic             pred_out_valid,
    output logic             pred_taken,
    output logic [IDX_W-1:0] pred_idx,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    output logic             ready
);
    localparam int DEPTH = 1 << IDX_W;

    // Requests and updates are valid-only (no backpressure): each is consumed on the edge
    // where it is sampled high, and only once ready is already 1; otherwise it is dropped.

    typedef enum logic {INIT, RUN} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] init_ptr_q, init_ptr_d;
    logic [1:0]       table_q [DEPTH];

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [1:0]       wr_data;
    logic [1:0]       upd_cur;
    logic [1:0]       upd_next;
    logic [IDX_W-1:0] pred_idx_c;
    logic             pred_hit_upd;
    logic             pred_taken_c;
    logic             unused_pc;

    assign unused_pc = ^{pred_pc[PC_W-1:IDX_W+2], pred_pc[1:0]};

    function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
        if (taken) return (cnt == 2'b11) ? cnt : cnt + 2'd1;
        else       return (cnt == 2'b00) ? cnt : cnt - 2'd1;
    endfunction

    assign upd_cur  = table_q[upd_idx];
    assign upd_next = sat_next(upd_cur, upd_taken);

    assign pred_idx_c   = pred_pc[IDX_W+1:2] ^ pred_ghr;
    // Same-index update in the same cycle: forward the post-update counter.
    assign pred_hit_upd = upd_valid && (upd_idx == pred_idx_c);
    assign pred_taken_c = pred_hit_upd ? upd_next[1] : table_q[pred_idx_c][1];

    assign ready = (state_q == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            init_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        wr_en      = 1'b0;
        wr_idx     = upd_idx;
        wr_data    = upd_next;
        case (state_q)
            INIT: begin
                wr_en      = 1'b1;
                wr_idx     = init_ptr_q;
                wr_data    = 2'b01;
                init_ptr_d = init_ptr_q + IDX_W'(1);
                if (&init_ptr_q) state_d = RUN;
            end
            RUN: begin
                wr_en = upd_valid;
            end
            default: state_d = INIT;
        endcase
    end

    // Counter storage has no reset; the sweep defines every entry before use.
    always_ff @(posedge clk) begin
        if (wr_en) table_q[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_out_valid <= 1'b0;
            pred_taken     <= 1'b0;
            pred_idx       <= '0;
        end else begin
            pred_out_valid <= (state_q == RUN) && pred_valid;
            if ((state_q == RUN) && pred_valid) begin
                pred_taken <= pred_taken_c;
                pred_idx   <= pred_idx_c;
            end
        end
    end

endmodule

// File: tb/tb_gshare_pht.sv
// Bench for gshare_pht: table-driven directed vectors, reset/sweep sequences and random
// traffic checked against a counter-array reference model.
module tb_gshare_pht;
    localparam int IDX_W = 8;
    localparam int PC_W  = 32;
    localparam int DEPTH = 1 << IDX_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             pred_valid = 1'b0;
    logic [PC_W-1:0]  pred_pc = '0;
    logic [IDX_W-1:0] pred_ghr = '0;
    logic             pred_out_valid;
    logic             pred_taken;
    logic [IDX_W-1:0] pred_idx;
    logic             upd_valid = 1'b0;
    logic [IDX_W-1:0] upd_idx = '0;
    logic             upd_taken = 1'b0;
    logic             ready;

    always #5 clk = ~clk;

    gshare_pht #(.IDX_W(IDX_W), .PC_W(PC_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_ghr(pred_ghr),
        .pred_out_valid(pred_out_valid), .pred_taken(pred_taken), .pred_idx(pred_idx),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .ready(ready)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: counter values 0..3 per entry, edge count since reset release.
    int               mdl [DEPTH];
    int               edge_cnt;
    logic [IDX_W-1:0] last_idx;
    logic             last_taken;
    logic [IDX_W:0]   exp_q[$];

    typedef struct {
        logic             pv;
        logic [PC_W-1:0]  pc;
        logic [IDX_W-1:0] ghr;
        logic             uv;
        logic [IDX_W-1:0] uidx;
        logic             ut;
        logic [IDX_W-1:0] eidx;
        logic             et;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [IDX_W-1:0] model_idx(input logic [PC_W-1:0] pc,
                                                    input logic [IDX_W-1:0] ghr);
        int unsigned word;
        word = pc / 4;
        return IDX_W'(word % DEPTH) ^ ghr;
    endfunction

    task automatic apply_reset();
        pred_valid = 1'b0;
        upd_valid  = 1'b0;
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_ready", ready, 0);
        check("rst_out_valid", pred_out_valid, 0);
        check("rst_taken", pred_taken, 0);
        check("rst_idx", pred_idx, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        edge_cnt = 0;
        foreach (mdl[i]) mdl[i] = 1;
        last_idx = '0;
        last_taken = 1'b0;
        exp_q.delete();
    endtask

    task automatic do_cycle(input logic pv, input logic [PC_W-1:0] pc, input logic [IDX_W-1:0] ghr,
                            input logic uv, input logic [IDX_W-1:0] uidx, input logic ut);
        logic             accepted;
        logic [IDX_W-1:0] pidx;
        logic [IDX_W:0]   e;
        accepted   = (edge_cnt >= DEPTH);
        pred_valid = pv;
        pred_pc    = pc;
        pred_ghr   = ghr;
        upd_valid  = uv;
        upd_idx    = uidx;
        upd_taken  = ut;
        pidx = model_idx(pc, ghr);
        if (accepted && uv) begin
            if (ut) mdl[uidx] = (mdl[uidx] < 3) ? mdl[uidx] + 1 : 3;
            else    mdl[uidx] = (mdl[uidx] > 0) ? mdl[uidx] - 1 : 0;
        end
        if (accepted && pv) exp_q.push_back({pidx, (mdl[pidx] >= 2)});
        @(posedge clk);
        #1;
        edge_cnt++;
        check("ready", ready, (edge_cnt >= DEPTH));
        if (accepted && pv) begin
            e = exp_q.pop_front();
            check("out_valid", pred_out_valid, 1);
            check("pred_idx", pred_idx, e[IDX_W:1]);
            check("pred_taken", pred_taken, e[0]);
            last_idx   = e[IDX_W:1];
            last_taken = e[0];
        end else begin
            check("no_out_valid", pred_out_valid, 0);
            check("hold_idx", pred_idx, last_idx);
            check("hold_taken", pred_taken, last_taken);
        end
        pred_valid = 1'b0;
        upd_valid  = 1'b0;
    endtask

    task automatic sweep(input int n);
        for (int i = 0; i < n; i++)
            do_cycle(1'($urandom_range(0, 1)), PC_W'($urandom), IDX_W'($urandom),
                     1'($urandom_range(0, 1)), IDX_W'($urandom), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h10, 8'h00, 1'b0, 8'h00, 1'b0, 8'h04, 1'b0};
        vecs[1]  = '{1'b1, 32'h10, 8'hFF, 1'b0, 8'h00, 1'b0, 8'hFB, 1'b0};
        vecs[2]  = '{1'b0, 32'h0,  8'h00, 1'b1, 8'h04, 1'b1, 8'h00, 1'b0};
        vecs[3]  = '{1'b1, 32'h10, 8'h00, 1'b0, 8'h00, 1'b0, 8'h04, 1'b1};
        vecs[4]  = '{1'b0, 32'h0,  8'h00, 1'b1, 8'h04, 1'b1, 8'h00, 1'b0};
        vecs[5]  = '{1'b0, 32'h0,  8'h00, 1'b1, 8'h04, 1'b1, 8'h00, 1'b0};
        vecs[6]  = '{1'b0, 32'h0,  8'h00, 1'b1, 8'h04, 1'b1, 8'h00, 1'b0};
        vecs[7]  = '{1'b0, 32'h0,  8'h00, 1'b1, 8'h04, 1'b0, 8'h00, 1'b0};
        vecs[8]  = '{1'b1, 32'h10, 8'h00, 1'b0, 8'h00, 1'b0, 8'h04, 1'b1};
        vecs[9]  = '{1'b0, 32'h0,  8'h00, 1'b1, 8'h04, 1'b0, 8'h00, 1'b0};
        vecs[10] = '{1'b0, 32'h0,  8'h00, 1'b1, 8'h04, 1'b0, 8'h00, 1'b0};
        vecs[11] = '{1'b1, 32'h10, 8'h00, 1'b0, 8'h00, 1'b0, 8'h04, 1'b0};
        vecs[12] = '{1'b0, 32'h0,  8'h00, 1'b1, 8'h04, 1'b0, 8'h00, 1'b0};
        vecs[13] = '{1'b0, 32'h0,  8'h00, 1'b1, 8'h04, 1'b0, 8'h00, 1'b0};
        vecs[14] = '{1'b1, 32'h10, 8'h00, 1'b0, 8'h00, 1'b0, 8'h04, 1'b0};
        vecs[15] = '{1'b1, 32'h80, 8'h00, 1'b1, 8'h20, 1'b1, 8'h20, 1'b1};
        vecs[16] = '{1'b1, 32'h80, 8'h00, 1'b0, 8'h00, 1'b0, 8'h20, 1'b1};

        // Init sweep with random requests/updates that must all be dropped.
        apply_reset();
        sweep(DEPTH - 1);
        check("ready_edge255", ready, 0);
        sweep(1);
        check("ready_edge256", ready, 1);

        for (int i = 0; i < 17; i++) begin
            do_cycle(vecs[i].pv, vecs[i].pc, vecs[i].ghr, vecs[i].uv, vecs[i].uidx, vecs[i].ut);
            if (vecs[i].pv) begin
                check($sformatf("vec%0d_idx", i), pred_idx, vecs[i].eidx);
                check($sformatf("vec%0d_taken", i), pred_taken, vecs[i].et);
            end
        end

        // Back-to-back: 8 requests, concurrent updates to other indices.
        begin
            logic [PC_W-1:0] base;
            logic [IDX_W-1:0] g, pi;
            base = PC_W'($urandom) & ~PC_W'(3);
            for (int i = 0; i < 8; i++) begin
                g  = IDX_W'($urandom);
                pi = model_idx(base + PC_W'(i * 4), g);
                do_cycle(1'b1, base + PC_W'(i * 4), g, 1'b1, pi ^ 8'h55, 1'($urandom_range(0, 1)));
            end
        end

        // Random traffic on a small index set so counters train and bypasses occur.
        for (int i = 0; i < 600; i++) begin
            logic [PC_W-1:0] pc;
            logic [IDX_W-1:0] g, ui;
            pc = PC_W'($urandom_range(0, 7)) << 2;
            g  = IDX_W'($urandom_range(0, 3));
            ui = ($urandom_range(0, 2) == 0) ? model_idx(pc, g) : IDX_W'($urandom_range(0, 7));
            do_cycle(1'($urandom_range(0, 1)), pc, g, 1'($urandom_range(0, 1)), ui,
                     1'($urandom_range(0, 1)));
        end

        // Reset mid-sweep at edge 100, with updates to 0x30 during both sweeps.
        apply_reset();
        for (int i = 0; i < 100; i++) do_cycle(1'b1, 32'hC0, 8'h00, 1'b1, 8'h30, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midsweep_ready_low", ready, 0);
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            do_cycle(1'b1, 32'hC0, 8'h00, 1'b1, 8'h30, 1'b1);
            if (i == DEPTH - 2) check("resweep_ready_255", ready, 0);
        end
        check("resweep_ready_256", ready, 1);
        do_cycle(1'b1, 32'hC0, 8'h00, 1'b0, 8'h00, 1'b0);
        check("sweep_upd_dropped", pred_taken, 0);
        check("sweep_upd_idx", pred_idx, 8'h30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
